// File: rtl/master_clk_enable.sv
// master_clk_enable
//   Clock-enable and reset sequencer for the master clock domain. Qualifies
//   the PLL lock flag, releases a downstream reset once lock has been stable
//   for LOCK_CYCLES cycles, then produces NUM_CH phase-aligned single-cycle
//   enable pulses with runtime-programmable divisors. New divisors are staged
//   in a shadow register and applied together at a channel-0 boundary.
//
// Ports
//   clk          master clock (PLL output)
//   rst_n        synchronous active-low reset
//   pll_locked   asynchronous PLL lock flag (2-flop synchronised here)
//   div_cfg      new divisors, channel i at [i*DIV_W +: DIV_W]
//   cfg_load     strobe: capture div_cfg into the shadow register
//   run          high = channel counters advance, low = counters hold
//   ce           enable pulses, one bit per channel
//   sys_rst_n    downstream active-low reset, high only in RUN
//   ready        high in RUN
//   cfg_pending  shadow loaded but not yet applied
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | synchronised lock low; stable counter held at 0
// STABLE    | lock seen; counting consecutive locked cycles
// RUN       | lock qualified; reset released, enables running

module master_clk_enable #(
   parameter int                       NUM_CH      = 2,
   parameter int                       DIV_W       = 5,
   parameter logic [NUM_CH*DIV_W-1:0]  DIV_INIT    = {5'd4, 5'd12},
   parameter int                       LOCK_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pll_locked,
   input  logic [NUM_CH*DIV_W-1:0]    div_cfg,
   input  logic                       cfg_load,
   input  logic                       run,
   output logic [NUM_CH-1:0]          ce,
   output logic                       sys_rst_n,
   output logic                       ready,
   output logic                       cfg_pending
);

   localparam int               STB_W   = $clog2(LOCK_CYCLES + 1);
   localparam logic [STB_W-1:0] STB_LIM = STB_W'(LOCK_CYCLES);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic                            sync1_q, sync1_d;
   logic                            sync2_q, sync2_d;
   logic [STB_W-1:0]                stb_q, stb_d, stb_inc;
   logic                            sys_rst_n_q, sys_rst_n_d;
   logic                            ready_q, ready_d;
   logic [NUM_CH*DIV_W-1:0]         active_q, active_d;
   logic [NUM_CH*DIV_W-1:0]         shadow_q, shadow_d;
   logic                            pending_q, pending_d;
   logic [NUM_CH-1:0][DIV_W-1:0]    cnt_q, cnt_d;

   logic [NUM_CH-1:0][DIV_W-1:0]    last_val;
   logic [NUM_CH-1:0]               ce_hit;
   logic                            apply;

   // Terminal count per channel; a divisor of 0 behaves as 1.
   always_comb begin
      last_val = '0;
      ce_hit   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (active_q[i*DIV_W +: DIV_W] == '0) begin
            last_val[i] = '0;
         end else begin
            last_val[i] = active_q[i*DIV_W +: DIV_W] - DIV_W'(1);
         end
         ce_hit[i] = (state_q == RUN) && run && (cnt_q[i] == last_val[i]);
      end
   end

   assign apply = ce_hit[0] & pending_q;

   // Lock qualification. The stable counter never passes STB_LIM: STABLE
   // leaves on the increment that reaches it and RUN holds the value.
   always_comb begin
      state_d = state_q;
      stb_d   = stb_q;
      stb_inc = stb_q + STB_W'(1);
      case (state_q)
         WAIT_LOCK: begin
            stb_d = '0;
            if (sync2_q) begin
               stb_d   = STB_W'(1);
               state_d = (STB_LIM == STB_W'(1)) ? RUN : STABLE;
            end
         end
         STABLE: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
               stb_d   = '0;
            end else begin
               stb_d = stb_inc;
               if (stb_inc == STB_LIM) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
               stb_d   = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            stb_d   = '0;
         end
      endcase
   end

   always_comb begin
      sync1_d     = pll_locked;
      sync2_d     = sync1_q;
      sys_rst_n_d = (state_d == RUN);
      ready_d     = (state_d == RUN);
      cnt_d       = cnt_q;
      // Counters sit at 0 on entry to and exit from RUN, and restart
      // together on an apply so all channels share channel-0 phase.
      for (int i = 0; i < NUM_CH; i++) begin
         if ((state_q != RUN) || (state_d != RUN) || apply) begin
            cnt_d[i] = '0;
         end else if (run) begin
            cnt_d[i] = (cnt_q[i] == last_val[i]) ? '0 : cnt_q[i] + DIV_W'(1);
         end
      end
      active_d  = apply ? shadow_q : active_q;
      shadow_d  = cfg_load ? div_cfg : shadow_q;
      // A load on the apply edge re-arms pending for the newly captured value.
      pending_d = cfg_load | (pending_q & ~apply);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= WAIT_LOCK;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         stb_q       <= '0;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         active_q    <= DIV_INIT;
         shadow_q    <= DIV_INIT;
         pending_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stb_q       <= stb_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         active_q    <= active_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ce          = ce_hit;
   assign sys_rst_n   = sys_rst_n_q;
   assign ready       = ready_q;
   assign cfg_pending = pending_q;

endmodule

// File: tb/tb_master_clk_enable.sv
module tb_master_clk_enable;

   localparam int LOCK = 16;

   logic       clk = 1'b0;
   logic       rst_n, pll_locked, cfg_load, run;
   logic [9:0] div_cfg;
   logic [1:0] ce;
   logic       sys_rst_n, ready, cfg_pending;

   master_clk_enable #(
      .NUM_CH      (2),
      .DIV_W       (5),
      .DIV_INIT    ({5'd4, 5'd12}),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .div_cfg     (div_cfg),
      .cfg_load    (cfg_load),
      .run         (run),
      .ce          (ce),
      .sys_rst_n   (sys_rst_n),
      .ready       (ready),
      .cfg_pending (cfg_pending)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   int run_cyc = 0;
   int n_ce0 = 0, n_ce1 = 0, n_misalign = 0;

   logic [1:0] s_ce;
   logic       s_srst, s_rdy, s_pend;
   int         s_edge;

   // reference model state
   int         m_state, m_stb;
   logic       m_s1, m_s2, m_pend;
   logic [4:0] m_cnt [2];
   logic [4:0] m_act [2];
   logic [4:0] m_sh  [2];

   typedef struct {
      logic [1:0] ce;
      logic       srst;
      logic       rdy;
      logic       pend;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      int         cyc;
      logic [1:0] exp_ce;
   } vec_t;
   vec_t vecs [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d edge=%0d", nm, act, exp, edge_n);
      end
   endtask

   function automatic logic [4:0] m_last(input logic [4:0] d);
      return (d == 5'd0) ? 5'd0 : d - 5'd1;
   endfunction

   function automatic logic [1:0] m_ce();
      logic [1:0] r = 2'b00;
      for (int i = 0; i < 2; i++)
         if (m_state == 2 && run && m_cnt[i] == m_last(m_act[i])) r[i] = 1'b1;
      return r;
   endfunction

   task automatic model_step();
      logic [1:0] ce_pre;
      logic       apply;
      int         nstate;
      if (!rst_n) begin
         m_state = 0; m_stb = 0; m_s1 = 0; m_s2 = 0; m_pend = 0;
         m_cnt[0] = 0; m_cnt[1] = 0;
         m_act[0] = 5'd12; m_act[1] = 5'd4;
         m_sh[0]  = 5'd12; m_sh[1]  = 5'd4;
         return;
      end
      ce_pre = m_ce();
      apply  = ce_pre[0] && m_pend;
      nstate = m_state;
      case (m_state)
         0: if (m_s2) begin m_stb = 1; nstate = (m_stb >= LOCK) ? 2 : 1; end
            else m_stb = 0;
         1: if (!m_s2) begin nstate = 0; m_stb = 0; end
            else begin m_stb++; if (m_stb == LOCK) nstate = 2; end
         default: if (!m_s2) begin nstate = 0; m_stb = 0; end
      endcase
      for (int i = 0; i < 2; i++) begin
         if (m_state != 2 || nstate != 2 || apply) m_cnt[i] = 0;
         else if (run) m_cnt[i] = (m_cnt[i] == m_last(m_act[i])) ? 5'd0 : m_cnt[i] + 5'd1;
      end
      if (apply) begin m_act[0] = m_sh[0]; m_act[1] = m_sh[1]; end
      if (cfg_load) begin
         m_sh[0] = div_cfg[4:0]; m_sh[1] = div_cfg[9:5]; m_pend = 1;
      end else if (apply) m_pend = 0;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      m_state = nstate;
   endtask

   // One clock cycle: predict, sample, compare, then advance past the edge.
   task automatic tick();
      exp_t e, g;
      #2;
      e.ce   = m_ce();
      e.srst = (m_state == 2);
      e.rdy  = (m_state == 2);
      e.pend = m_pend;
      sb_q.push_back(e);
      s_ce = ce; s_srst = sys_rst_n; s_rdy = ready; s_pend = cfg_pending;
      s_edge = edge_n;
      g = sb_q.pop_front();
      chk("ce", {30'd0, s_ce}, {30'd0, g.ce});
      chk("sys_rst_n", {31'd0, s_srst}, {31'd0, g.srst});
      chk("ready", {31'd0, s_rdy}, {31'd0, g.rdy});
      chk("cfg_pending", {31'd0, s_pend}, {31'd0, g.pend});
      if (s_rdy === 1'b1) begin
         run_cyc++;
         if (s_ce[0] === 1'b1) n_ce0++;
         if (s_ce[1] === 1'b1) n_ce1++;
         if (s_ce[0] === 1'b1 && s_ce[1] !== 1'b1) n_misalign++;
      end else run_cyc = 0;
      @(posedge clk);
      edge_n++;
      model_step();
      #1;
   endtask

   task automatic run_to(input int c);
      int g = 0;
      while (run_cyc < c && g < 400) begin tick(); g++; end
   endtask

   task automatic wait_ready(output int ed);
      int n = 0;
      ed = -1;
      do begin tick(); n++; end while (s_rdy !== 1'b1 && n < 200);
      if (s_rdy === 1'b1) ed = s_edge;
   endtask

   task automatic first_ce(output int f0, output int f1);
      f0 = 0; f1 = 0;
      for (int g = 0; g < 100; g++) begin
         if (s_ce[0] === 1'b1 && f0 == 0) f0 = run_cyc;
         if (s_ce[1] === 1'b1 && f1 == 0) f1 = run_cyc;
         if (f0 != 0 && f1 != 0) break;
         tick();
      end
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish edge=%0d", edge_n);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int ed, e0, r_edge, f0, f1, n0, n1, npause, g;

      vecs[0] = '{1,  2'b00};
      vecs[1] = '{3,  2'b00};
      vecs[2] = '{4,  2'b10};
      vecs[3] = '{8,  2'b10};
      vecs[4] = '{11, 2'b00};
      vecs[5] = '{12, 2'b11};
      vecs[6] = '{13, 2'b00};
      vecs[7] = '{16, 2'b10};
      vecs[8] = '{23, 2'b00};
      vecs[9] = '{24, 2'b11};

      rst_n = 1'b0; pll_locked = 1'b0; run = 1'b1; cfg_load = 1'b0; div_cfg = '0;
      repeat (3) begin @(posedge clk); model_step(); end
      #1;
      rst_n = 1'b1;
      edge_n = 0;

      // startup: lock first sampled at edge 10
      while (edge_n < 9) tick();
      pll_locked = 1'b1;
      wait_ready(ed);
      chk("startup_ready_edge", ed, 27);
      for (int v = 0; v < 10; v++) begin
         run_to(vecs[v].cyc);
         chk($sformatf("startup_ce_cyc%0d", vecs[v].cyc), {30'd0, s_ce}, {30'd0, vecs[v].exp_ce});
      end
      run_to(120);
      chk("ntsc_ce0_count", n_ce0, 10);
      chk("ntsc_ce1_count", n_ce1, 30);
      chk("ntsc_misalign", n_misalign, 0);

      // PAL switch loaded at period cycle 5
      run_to(124);
      cfg_load = 1'b1; div_cfg = {5'd5, 5'd16};
      tick();
      cfg_load = 1'b0;
      tick();
      chk("pal_pending_set", {31'd0, s_pend}, 1);
      run_to(132);
      chk("pal_apply_ce0", {31'd0, s_ce[0]}, 1);
      f0 = 0; f1 = 0; n0 = 0; n1 = 0;
      for (int c = 133; c <= 164; c++) begin
         tick();
         if (c == 133) chk("pal_pending_clear", {31'd0, s_pend}, 0);
         if (s_ce[0] === 1'b1) begin n0++; if (f0 == 0) f0 = run_cyc; end
         if (s_ce[1] === 1'b1) begin if (f1 == 0) f1 = run_cyc; if (run_cyc <= 162) n1++; end
      end
      chk("pal_first_ce0", f0, 148);
      chk("pal_ce0_count", n0, 2);
      chk("pal_first_ce1", f1, 137);
      chk("pal_ce1_count", n1, 6);

      // pause for 7 cycles
      run_to(169);
      run = 1'b0; npause = 0;
      repeat (7) begin tick(); if (s_ce !== 2'b00) npause++; end
      run = 1'b1;
      chk("pause_no_ce", npause, 0);
      g = 0;
      do begin tick(); g++; end while (s_ce[0] !== 1'b1 && g < 60);
      chk("pause_next_ce0", run_cyc, 187);

      // lock loss in RUN
      pll_locked = 1'b0;
      tick(); tick(); tick();
      chk("lockloss_srst_m1", {31'd0, s_srst}, 1);
      tick();
      chk("lockloss_srst_m2", {31'd0, s_srst}, 0);
      chk("lockloss_ready_m2", {31'd0, s_rdy}, 0);
      chk("lockloss_ce_m2", {30'd0, s_ce}, 0);
      pll_locked = 1'b1;
      e0 = edge_n;
      wait_ready(ed);
      chk("relock_ready_edge", ed, e0 + 18);
      first_ce(f0, f1);
      chk("relock_pal_ce0", f0, 16);
      chk("relock_pal_ce1", f1, 5);

      // synchronous reset pulse with a pending load, then a lock glitch
      cfg_load = 1'b1; div_cfg = {5'd3, 5'd9};
      tick();
      cfg_load = 1'b0;
      tick();
      chk("rst_pending_before", {31'd0, s_pend}, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      r_edge = edge_n;
      tick();
      chk("rst_pending_after", {31'd0, s_pend}, 0);
      chk("rst_ready_after", {31'd0, s_rdy}, 0);
      chk("rst_srst_after", {31'd0, s_srst}, 0);
      repeat (9) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_ready(ed);
      chk("glitch_ready_edge", ed, r_edge + 29);
      first_ce(f0, f1);
      chk("rst_init_ce0", f0, 12);
      chk("rst_init_ce1", f1, 4);

      // divisor 0 on channel 1, plus a load coinciding with the apply edge
      run_to(13);
      cfg_load = 1'b1; div_cfg = {5'd0, 5'd12};
      tick();
      cfg_load = 1'b0;
      run_to(23);
      cfg_load = 1'b1; div_cfg = {5'd2, 5'd6};
      tick();
      cfg_load = 1'b0;
      chk("coinc_ce0", {31'd0, s_ce[0]}, 1);
      n1 = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 0) chk("coinc_pending_kept", {31'd0, s_pend}, 1);
         if (s_ce[1] === 1'b1) n1++;
      end
      chk("div0_ce1_every_cycle", n1, 12);
      chk("second_apply_ce0", {31'd0, s_ce[0]}, 1);
      tick();
      chk("second_apply_pending", {31'd0, s_pend}, 0);
      g = 0;
      while (s_ce[0] !== 1'b1 && g < 40) begin tick(); g++; end
      chk("div6_next_ce0", run_cyc, 42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
